// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the writeback entry type for the regfile writeback path
package wb_pkg;
   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 32;
   localparam int REG_COUNT  = 16;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;
endpackage

// File: rtl/regfile_wb_ctrl_fifo.sv
// wb_fifo: in-order writeback queue with 0-2 pushes (a older than b) and 0-1 pop per cycle
// Ports: clk, rst (async, active-high); push_a/ent_a, push_b/ent_b, pop;
//        ents/vld present the queue in age order (index 0 = head); count = occupancy.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_a,
   input  wb_entry_t       ent_a,
   input  logic            push_b,
   input  wb_entry_t       ent_b,
   input  logic            pop,
   output wb_entry_t       ents [DEPTH],
   output logic [DEPTH-1:0] vld,
   output logic [PTR_W:0]  count
);
   typedef logic [PTR_W:0] cnt_t;
   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d, wr_b;
   cnt_t             count_q, count_d;
   always_comb begin
      mem_d = mem_q;
      wr_b  = push_a ? wr_q + PTR_W'(1) : wr_q;
      if (push_a) mem_d[wr_q] = ent_a;
      if (push_b) mem_d[wr_b] = ent_b;
      wr_d    = wr_q + PTR_W'(push_a) + PTR_W'(push_b);
      rd_d    = rd_q + PTR_W'(pop);
      count_d = count_q + cnt_t'(push_a) + cnt_t'(push_b) - cnt_t'(pop);
      count   = count_q;
      for (int k = 0; k < DEPTH; k++) begin
         ents[k] = mem_q[rd_q + PTR_W'(k)];
         vld[k]  = cnt_t'(k) < count_q;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   // storage needs no reset: entries are only observed through vld
   always_ff @(posedge clk)
      mem_q <= mem_d;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: arbitrates ALU/load writebacks into a FIFO drained one write per cycle
// Ports: clk, rst (async, active-high); alu*/mem* valid/ready producers; writeAddr/writeData/regwe
//        to the register file; pendingMask for decode hazards. WB_BYPASS_EN adds fwdAddr/fwdHit/fwdData lookups.
module regfile_wb_ctrl
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  aluValid,
   input  logic [REG_ADDR_W-1:0] aluAddr,
   input  logic [DATA_W-1:0]     aluData,
   output logic                  aluReady,
   input  logic                  memValid,
   input  logic [REG_ADDR_W-1:0] memAddr,
   input  logic [DATA_W-1:0]     memData,
   output logic                  memReady,
   output logic [REG_ADDR_W-1:0] writeAddr,
   output logic [DATA_W-1:0]     writeData,
   output logic                  regwe,
   output logic [REG_COUNT-1:0]  pendingMask
`ifdef WB_BYPASS_EN
   ,
   input  logic [REG_ADDR_W-1:0] fwdAddr1,
   input  logic [REG_ADDR_W-1:0] fwdAddr2,
   output logic                  fwdHit1,
   output logic                  fwdHit2,
   output logic [DATA_W-1:0]     fwdData1,
   output logic [DATA_W-1:0]     fwdData2
`endif
);
   typedef logic [PTR_W:0] cnt_t;
   wb_entry_t      ents [DEPTH];
   logic [DEPTH-1:0] vld;
   cnt_t           count, free;
   logic           rr_q, rr_d;
   logic           alu_req, mem_req, alu_ok, mem_ok, push_a, push_b;
   wb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push_a(push_a),
      .ent_a ('{addr: aluAddr, data: aluData}),
      .push_b(push_b),
      .ent_b ('{addr: memAddr, data: memData}),
      .pop   (regwe),
      .ents  (ents),
      .vld   (vld),
      .count (count)
   );
   always_comb begin
      free    = cnt_t'(DEPTH) - count;
      alu_req = aluValid && aluAddr != '0;
      mem_req = memValid && memAddr != '0;
      // with one free slot a competing request wins only when rr points at it
      alu_ok  = free >= cnt_t'(2) || (free == cnt_t'(1) && !(mem_req && rr_q));
      mem_ok  = free >= cnt_t'(2) || (free == cnt_t'(1) && !(alu_req && !rr_q));
      push_a  = alu_req && alu_ok;
      push_b  = mem_req && mem_ok;
      rr_d    = rr_q ^ (free == cnt_t'(1) && alu_req && mem_req);
      // address-0 writes are swallowed without touching the queue
      aluReady = !rst && (aluAddr == '0 || alu_ok);
      memReady = !rst && (memAddr == '0 || mem_ok);
      regwe     = vld[0];
      writeAddr = regwe ? ents[0].addr : '0;
      writeData = regwe ? ents[0].data : '0;
      pendingMask = '0;
      for (int k = 0; k < DEPTH; k++)
         if (vld[k]) pendingMask[ents[k].addr] = 1'b1;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) rr_q <= 1'b0;
      else     rr_q <= rr_d;
`ifdef WB_BYPASS_EN
   // scan oldest to youngest so the last match is the youngest entry
   always_comb begin
      fwdHit1  = 1'b0;
      fwdHit2  = 1'b0;
      fwdData1 = '0;
      fwdData2 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (vld[k] && fwdAddr1 != '0 && ents[k].addr == fwdAddr1) begin
            fwdHit1  = 1'b1;
            fwdData1 = ents[k].data;
         end
         if (vld[k] && fwdAddr2 != '0 && ents[k].addr == fwdAddr2) begin
            fwdHit2  = 1'b1;
            fwdData2 = ents[k].data;
         end
      end
   end
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed and random checks of regfile_wb_ctrl against a queue model
module tb_regfile_wb_ctrl;
   localparam int DEPTH = 4;
   typedef struct packed { logic [3:0] a; logic [31:0] d; } ent_t;
   logic        clk = 1'b0, rst = 1'b1;
   logic        aluValid = 0, memValid = 0, aluReady, memReady, regwe;
   logic [3:0]  aluAddr = 0, memAddr = 0, writeAddr;
   logic [31:0] aluData = 0, memData = 0, writeData;
   logic [15:0] pendingMask;
   logic [3:0]  fwdAddr1 = 0, fwdAddr2 = 0;
`ifdef WB_BYPASS_EN
   logic        fwdHit1, fwdHit2;
   logic [31:0] fwdData1, fwdData2;
`endif
   int total = 0, bad = 0;
   ent_t q[$];
   bit   rr_m = 0;
   always #5 clk = ~clk;
   regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData), .aluReady(aluReady),
      .memValid(memValid), .memAddr(memAddr), .memData(memData), .memReady(memReady),
      .writeAddr(writeAddr), .writeData(writeData), .regwe(regwe), .pendingMask(pendingMask)
`ifdef WB_BYPASS_EN
      , .fwdAddr1(fwdAddr1), .fwdAddr2(fwdAddr2), .fwdHit1(fwdHit1), .fwdHit2(fwdHit2),
      .fwdData1(fwdData1), .fwdData2(fwdData2)
`endif
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask
   // admission rules: >=2 free take both, 1 free pick by round robin when contended
   function automatic void admit(input bit ar, input bit mr, input int fr, input bit rr,
                                 output bit ga, output bit gm);
      ga = 0;
      gm = 0;
      if (fr >= 2) begin ga = ar; gm = mr; end
      else if (fr == 1) begin
         if (ar && mr) begin ga = !rr; gm = rr; end
         else begin ga = ar; gm = mr; end
      end
   endfunction
   bit   ar_u, mr_u, ga_u, gm_u;
   int   fr_u;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         rr_m = 0;
      end else begin
         ar_u = aluValid && aluAddr != 0;
         mr_u = memValid && memAddr != 0;
         fr_u = DEPTH - q.size();
         admit(ar_u, mr_u, fr_u, rr_m, ga_u, gm_u);
         if (ar_u && mr_u && fr_u == 1) rr_m = !rr_m;
         if (q.size() != 0) void'(q.pop_front());
         if (ga_u) q.push_back({aluAddr, aluData});
         if (gm_u) q.push_back({memAddr, memData});
      end
   end
   bit          ga_c, gm_c, dummy;
   logic [15:0] m_c;
`ifdef WB_BYPASS_EN
   logic        h1, h2;
   logic [31:0] d1, d2;
`endif
   always @(negedge clk) begin
      chk("regwe", 32'(regwe), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("writeAddr", 32'(writeAddr), 32'(q[0].a));
         chk("writeData", writeData, q[0].d);
      end
      m_c = 0;
      foreach (q[i]) m_c[q[i].a] = 1'b1;
      chk("pendingMask", 32'(pendingMask), 32'(m_c));
      if (rst) begin
         chk("aluReady_rst", 32'(aluReady), 0);
         chk("memReady_rst", 32'(memReady), 0);
      end else begin
         if (aluValid) begin
            admit(1'b1, memValid && memAddr != 0, DEPTH - q.size(), rr_m, ga_c, dummy);
            chk("aluReady", 32'(aluReady), 32'(aluAddr == 0 || ga_c));
         end
         if (memValid) begin
            admit(aluValid && aluAddr != 0, 1'b1, DEPTH - q.size(), rr_m, dummy, gm_c);
            chk("memReady", 32'(memReady), 32'(memAddr == 0 || gm_c));
         end
      end
`ifdef WB_BYPASS_EN
      h1 = 0; h2 = 0; d1 = 0; d2 = 0;
      foreach (q[i]) begin
         if (fwdAddr1 != 0 && q[i].a == fwdAddr1) begin h1 = 1; d1 = q[i].d; end
         if (fwdAddr2 != 0 && q[i].a == fwdAddr2) begin h2 = 1; d2 = q[i].d; end
      end
      chk("fwdHit1", 32'(fwdHit1), 32'(h1));
      chk("fwdData1", fwdData1, d1);
      chk("fwdHit2", 32'(fwdHit2), 32'(h2));
      chk("fwdData2", fwdData2, d2);
`endif
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic at_neg;
      @(negedge clk);
      #1;
   endtask
   bit ar_s [5], mr_s [5];
   bit acc_a, acc_m;
   initial begin
      repeat (2) at_neg;
      chk("rst_regwe", 32'(regwe), 0);
      chk("rst_waddr", 32'(writeAddr), 0);
      chk("rst_wdata", writeData, 0);
      chk("rst_mask", 32'(pendingMask), 0);
      chk("rst_ardy", 32'(aluReady), 0);
      chk("rst_mrdy", 32'(memReady), 0);
      tick;
      rst = 0;
      tick;
      aluValid = 1; aluAddr = 3; aluData = 32'h1234_5678;
      tick;
      aluValid = 0;
      at_neg;
      chk("t1_regwe", 32'(regwe), 1);
      chk("t1_waddr", 32'(writeAddr), 3);
      chk("t1_wdata", writeData, 32'h1234_5678);
      chk("t1_mask", 32'(pendingMask), 32'h0008);
      tick;
      at_neg;
      chk("t1_regwe_off", 32'(regwe), 0);
      chk("t1_mask_off", 32'(pendingMask), 0);
      tick;
      aluValid = 1; aluAddr = 5; aluData = 32'hA;
      memValid = 1; memAddr = 5; memData = 32'hB;
      tick;
      aluValid = 0; memValid = 0;
      at_neg;
      chk("t2_first", writeData, 32'hA);
      chk("t2_mask1", 32'(pendingMask), 32'h0020);
      tick;
      at_neg;
      chk("t2_second", writeData, 32'hB);
      chk("t2_mask2", 32'(pendingMask), 32'h0020);
      tick;
      at_neg;
      chk("t2_empty", 32'(regwe), 0);
      tick;
      aluValid = 1; aluAddr = 1; aluData = 32'h100;
      memValid = 1; memAddr = 2; memData = 32'h200;
      for (int i = 0; i < 5; i++) begin
         at_neg;
         ar_s[i] = aluReady;
         mr_s[i] = memReady;
         tick;
         if (ar_s[i]) aluData++;
         if (mr_s[i]) memData++;
      end
      chk("t3_grants_alu", {27'b0, ar_s[0], ar_s[1], ar_s[2], ar_s[3], ar_s[4]}, 32'b11101);
      chk("t3_grants_mem", {27'b0, mr_s[0], mr_s[1], mr_s[2], mr_s[3], mr_s[4]}, 32'b11010);
      memAddr = 0;
      at_neg;
      chk("t4_mrdy_zero", 32'(memReady), 1);
      chk("t4_ardy", 32'(aluReady), 1);
      tick;
      aluValid = 0; memValid = 0;
      repeat (5) tick;
      aluValid = 1; aluAddr = 1; memValid = 1; memAddr = 2;
      tick;
      aluAddr = 3; memAddr = 4;
      tick;
      aluValid = 0; memValid = 0;
      chk("t5_mask3", 32'(pendingMask), 32'h001C);
      #1 rst = 1;
      #1;
      chk("t5_rst_regwe", 32'(regwe), 0);
      chk("t5_rst_mask", 32'(pendingMask), 0);
      tick;
      rst = 0;
      repeat (2) begin
         at_neg;
         chk("t5_no_stale", 32'(regwe), 0);
      end
`ifdef WB_BYPASS_EN
      tick;
      aluValid = 1; aluAddr = 7; aluData = 1;
      memValid = 1; memAddr = 7; memData = 2;
      tick;
      aluValid = 0; memValid = 0;
      fwdAddr1 = 7; fwdAddr2 = 0;
      #1;
      chk("bp_hit1", 32'(fwdHit1), 1);
      chk("bp_data1", fwdData1, 2);
      chk("bp_hit2", 32'(fwdHit2), 0);
`endif
      tick;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         acc_a = aluValid && aluReady;
         acc_m = memValid && memReady;
         tick;
         rst = (n % 700 == 350);
         if (!aluValid || acc_a) begin
            aluValid = $urandom_range(0, 3) != 0;
            aluAddr  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            aluData  = $urandom;
         end
         if (!memValid || acc_m) begin
            memValid = $urandom_range(0, 3) != 0;
            memAddr  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            memData  = $urandom;
         end
         fwdAddr1 = 4'($urandom_range(0, 15));
         fwdAddr2 = 4'($urandom_range(0, 15));
      end
      aluValid = 0; memValid = 0; rst = 0;
      repeat (6) tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
